// File: rtl/bitonic_pkg.sv
// Shared types and index helpers for the bitonic sort sequencer.
// Holds the controller state encoding, the pass count and the pair addressing.
package bitonic_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Number of (k, j) passes in a full bitonic network of 2**logn words.
  function automatic int pass_count(input int logn);
    return logn * (logn + 1) / 2;
  endfunction

  // Lower index of pair p at stride 2**jl; the partner is lo | 2**jl.
  function automatic int pair_lo(input int p, input int jl);
    return ((p >> jl) << (jl + 1)) | (p & ((1 << jl) - 1));
  endfunction

endpackage

// File: rtl/bitonic_cas_cell.sv
// Registered compare-exchange cell: o1/o2 update one cycle after an enabled issue.
// dir = 0 gives (min, max), dir = 1 gives (max, min); ties pass A/B straight through.
module bitonic_cas_cell #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         dir,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2
);

  logic swap;

  assign swap = dir ? (b > a) : (a > b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o1 <= '0;
      o2 <= '0;
    end else if (enable) begin
      o1 <= swap ? b : a;
      o2 <= swap ? a : b;
    end
  end

endmodule

// File: rtl/bitonic_sort_sequencer.sv
// Serial-load, in-place bitonic sorter built around one shared compare-exchange cell.
// LOAD accepts N words, SORT walks every (k, j, p) pair, DRAIN streams the result.
module bitonic_sort_sequencer
  import bitonic_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_desc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int LOGN   = $clog2(N);
  localparam int CW     = LOGN + 1;
  localparam int HALF   = N / 2;
  localparam int PASSES = pass_count(LOGN);
  localparam int PW     = $clog2(PASSES + 1);

  state_t          state_reg, state_next;
  logic [W-1:0]    mem_reg  [N];
  logic [W-1:0]    mem_next [N];
  logic [LOGN-1:0] wr_idx_reg, wr_idx_next;
  logic [LOGN-1:0] rd_idx_reg, rd_idx_next;
  logic            desc_reg, desc_next;
  logic [CW-1:0]   k_log_reg, k_log_next;
  logic [CW-1:0]   j_log_reg, j_log_next;
  logic [CW-1:0]   p_reg, p_next;
  logic [PW-1:0]   pass_reg, pass_next;
  logic [LOGN-1:0] wb_lo_reg, wb_hi_reg;
  logic            wb_valid_reg;

  logic [LOGN-1:0] lo, hi;
  logic [CW-1:0]   lo_ext;
  logic            cell_en, cell_dir;
  logic [W-1:0]    cell_o1, cell_o2;
  logic            in_fire, out_fire;

  assign in_fire  = in_valid && (state_reg == LOAD);
  assign out_fire = out_ready && (state_reg == DRAIN);

  // p_reg == HALF marks the bubble slot that lets the last writeback of a pass land.
  assign lo       = LOGN'(pair_lo(int'(p_reg), int'(j_log_reg)));
  assign hi       = lo | LOGN'(1 << j_log_reg);
  assign lo_ext   = CW'(lo);
  assign cell_dir = (|(lo_ext & (CW'(1) << k_log_reg))) ^ desc_reg;
  assign cell_en  = (state_reg == SORT) && (p_reg < CW'(HALF));

  bitonic_cas_cell #(.W(W)) u_cell (
    .clk    (clk),
    .rst    (rst),
    .enable (cell_en),
    .dir    (cell_dir),
    .a      (mem_reg[lo]),
    .b      (mem_reg[hi]),
    .o1     (cell_o1),
    .o2     (cell_o2)
  );

  // Loads and writebacks never coincide: writebacks only occur during SORT.
  for (genvar gi = 0; gi < N; gi++) begin : g_mem
    assign mem_next[gi] =
      (in_fire && (wr_idx_reg == LOGN'(gi)))      ? in_data :
      (wb_valid_reg && (wb_lo_reg == LOGN'(gi)))  ? cell_o1 :
      (wb_valid_reg && (wb_hi_reg == LOGN'(gi)))  ? cell_o2 :
                                                    mem_reg[gi];
  end

  always_comb begin
    state_next  = state_reg;
    wr_idx_next = wr_idx_reg;
    rd_idx_next = rd_idx_reg;
    desc_next   = desc_reg;
    k_log_next  = k_log_reg;
    j_log_next  = j_log_reg;
    p_next      = p_reg;
    pass_next   = pass_reg;
    case (state_reg)
      LOAD: begin
        if (in_fire) begin
          wr_idx_next = wr_idx_reg + 1'b1;
          if (wr_idx_reg == '0) desc_next = in_desc;
          if (wr_idx_reg == LOGN'(N - 1)) begin
            state_next = SORT;
            k_log_next = CW'(1);
            j_log_next = '0;
            p_next     = '0;
            pass_next  = '0;
          end
        end
      end
      SORT: begin
        if (p_reg == CW'(HALF)) begin
          p_next = '0;
          if (pass_reg == PW'(PASSES - 1)) begin
            state_next = DRAIN;
          end else begin
            pass_next = pass_reg + 1'b1;
            if (j_log_reg == '0) begin
              k_log_next = k_log_reg + 1'b1;
              j_log_next = k_log_reg;
            end else begin
              j_log_next = j_log_reg - 1'b1;
            end
          end
        end else begin
          p_next = p_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          rd_idx_next = rd_idx_reg + 1'b1;
          if (rd_idx_reg == LOGN'(N - 1)) state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= LOAD;
      wr_idx_reg   <= '0;
      rd_idx_reg   <= '0;
      desc_reg     <= 1'b0;
      k_log_reg    <= '0;
      j_log_reg    <= '0;
      p_reg        <= '0;
      pass_reg     <= '0;
      wb_lo_reg    <= '0;
      wb_hi_reg    <= '0;
      wb_valid_reg <= 1'b0;
      for (int i = 0; i < N; i++) mem_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      wr_idx_reg   <= wr_idx_next;
      rd_idx_reg   <= rd_idx_next;
      desc_reg     <= desc_next;
      k_log_reg    <= k_log_next;
      j_log_reg    <= j_log_next;
      p_reg        <= p_next;
      pass_reg     <= pass_next;
      wb_lo_reg    <= lo;
      wb_hi_reg    <= hi;
      wb_valid_reg <= cell_en;
      mem_reg      <= mem_next;
    end
  end

  assign in_ready  = (state_reg == LOAD);
  assign busy      = (state_reg == SORT);
  assign out_valid = (state_reg == DRAIN);
  assign out_data  = (state_reg == DRAIN) ? mem_reg[rd_idx_reg] : '0;

endmodule

// File: tb/tb_bitonic_sort_sequencer.sv
// Scoreboard bench: expected batches come from a plain queue sort and are popped by a monitor.
module tb_bitonic_sort_sequencer;

  localparam int N        = 8;
  localparam int W        = 32;
  localparam int LG       = $clog2(N);
  localparam int EXP_BUSY = (LG * (LG + 1) / 2) * (N / 2 + 1);

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_desc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] batch[N];
  bit stall_mode = 0;
  bit gap_mode   = 0;
  bit skip_busy  = 0;

  bitonic_sort_sequencer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_desc   (in_desc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: drives out_ready, pops the scoreboard on each output handshake.
  initial begin
    logic         held_valid;
    logic [W-1:0] held_data;
    logic [W-1:0] exp;
    int           busy_cnt;
    held_valid = 1'b0;
    held_data  = '0;
    busy_cnt   = 0;
    out_ready  = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_valid = 1'b0;
        busy_cnt   = 0;
        skip_busy  = 0;
        continue;
      end
      if (held_valid) begin
        check("stall_valid", W'(out_valid), W'(1));
        check("stall_data", out_data, held_data);
      end
      if (busy || out_valid) check("in_ready_low", W'(in_ready), W'(0));
      if (busy) begin
        busy_cnt++;
      end else if (busy_cnt != 0) begin
        if (!skip_busy) check("busy_cycles", W'(busy_cnt), W'(EXP_BUSY));
        busy_cnt  = 0;
        skip_busy = 0;
      end
      out_ready  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h expected no output", out_data);
        end else begin
          exp = sb_q.pop_front();
          $display("out word %h (expected %h)", out_data, exp);
          check("out_data", out_data, exp);
        end
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, input logic ds);
    int cnt;
    cnt = 0;
    @(negedge clk);
    if (gap_mode) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_desc  = ds;
    while (!in_ready && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 2000 cycles");
    end
    @(posedge clk);
  endtask

  task automatic run_batch(input bit ds, input bit noise, input bit push);
    logic [W-1:0] q[$];
    for (int i = 0; i < N; i++) q.push_back(batch[i]);
    if (ds) q.rsort();
    else q.sort();
    if (push) foreach (q[i]) sb_q.push_back(q[i]);
    for (int i = 0; i < N; i++)
      send_word(batch[i], (i == 0) ? ds : (noise ? 1'($urandom_range(0, 1)) : ds));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while (sb_q.size() != 0 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_batch();
    for (int i = 0; i < N; i++)
      batch[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom());
  endtask

  initial begin
    int cnt;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_desc  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_out_data", out_data, W'(0));
    rst = 1'b0;

    batch = '{32'd5, 32'd3, 32'd8, 32'd1, 32'd9, 32'd2, 32'd7, 32'd4};
    run_batch(1'b0, 1'b0, 1'b1);
    idle();
    wait_drain();

    run_batch(1'b1, 1'b1, 1'b1);
    idle();
    wait_drain();

    batch = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h7FFFFFFF,
              32'h0, 32'hFFFFFFFF, 32'h1, 32'h1};
    run_batch(1'b0, 1'b0, 1'b1);
    idle();
    wait_drain();

    stall_mode = 1;
    gap_mode   = 1;
    for (int b = 0; b < 3; b++) begin
      rand_batch();
      run_batch(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    idle();
    wait_drain();
    stall_mode = 0;
    gap_mode   = 0;

    rand_batch();
    run_batch(1'b0, 1'b0, 1'b0);
    idle();
    cnt = 0;
    while (!busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("sort_started", W'(busy), W'(1));
    repeat (10) @(posedge clk);
    skip_busy = 1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(1));
    check("midrst_out_data", out_data, W'(0));
    @(negedge clk);
    rst = 1'b0;

    batch = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    run_batch(1'b0, 1'b0, 1'b1);
    rand_batch();
    run_batch(1'b0, 1'b0, 1'b1);
    idle();
    wait_drain();
    check("final_in_ready", W'(in_ready), W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
